// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: EX-stage load writing a register that ID reads.
// Purely combinational, zero latency; no backpressure of its own.
module pipe_hazard_detect #(
    parameter int REGFILE_ADDRESS_WIDTH = 5
) (
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] id_rs2,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] ex_rd,
    input  logic                             ex_mem_read,
    output logic                             load_use
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage capture enables and flushes for a 5-stage pipe.
// Controls are combinational from registered state plus current inputs (zero latency).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGFILE_ADDRESS_WIDTH = 5,
    parameter int MEM_LATENCY           = 3,
    parameter int CNT_WIDTH             = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] id_rs2,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] ex_rd,
    input  logic                             ex_mem_read,
    input  logic                             ex_branch_taken,
    input  logic                             mem_access,
    input  logic                             wb_halt,
    output logic                             pc_en,
    output logic                             ifid_en,
    output logic                             idex_en,
    output logic                             exmem_en,
    output logic                             memwb_en,
    output logic                             ifid_flush,
    output logic                             idex_flush,
    output logic                             exmem_flush,
    output logic                             memwb_flush,
    output logic [STATE_W-1:0]               state,
    output logic [CNT_WIDTH-1:0]             stall_count
);

    localparam int WAIT_W = (MEM_LATENCY > 3) ? $clog2(MEM_LATENCY - 2) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (MEM_LATENCY > 2) ? WAIT_W'(MEM_LATENCY - 3) : '0;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 mem_done_q, mem_done_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 load_use;
    logic                 freeze;

    pipe_hazard_detect #(
        .REGFILE_ADDRESS_WIDTH(REGFILE_ADDRESS_WIDTH)
    ) u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // mem_done marks the one advancing cycle after a freeze, where mem_access is ignored.
    assign freeze = mem_access && !mem_done_q && (MEM_LATENCY > 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            mem_done_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mem_done_q <= mem_done_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_done_d = mem_done_q;
        stall_d    = stall_q;
        case (state_q)
            RUN: begin
                mem_done_d = 1'b0;
                if (wb_halt) begin
                    state_d = HALTED;
                end else if (freeze) begin
                    if (MEM_LATENCY > 2) begin
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_INIT;
                    end else begin
                        mem_done_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (wait_q == '0) begin
                    state_d    = RUN;
                    mem_done_d = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d    = RUN;
                    wait_d     = '0;
                    mem_done_d = 1'b0;
                end
            end
        endcase

        if ((state_q == IDLE || state_q == HALTED) && start)
            stall_d = '0;
        else if ((state_q == RUN || state_q == MEM_WAIT) && !pc_en && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        case (state_q)
            IDLE: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
            end
            RUN: begin
                if (wb_halt) begin
                    pc_en = 1'b0;
                end else if (freeze) begin
                    memwb_flush = 1'b1;
                end else if (ex_branch_taken) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
            end
            MEM_WAIT: begin
                memwb_flush = 1'b1;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    assign state       = state_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl (MEM_LATENCY=3, CNT_WIDTH=4).
module tb_pipe_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          ex_mem_read, ex_branch_taken, mem_access, wb_halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]    state;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .REGFILE_ADDRESS_WIDTH(AW),
        .MEM_LATENCY(3),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .state(state), .stall_count(stall_count)
    );

    typedef struct {
        logic          st;
        logic [AW-1:0] rs1, rs2, rd;
        logic          mr, br, ma, halt;
        logic [4:0]    en;   // {pc, ifid, idex, exmem, memwb}
        logic [3:0]    fl;   // {ifid, idex, exmem, memwb}
        logic [1:0]    state;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, int rs1, int rs2, int rd, logic mr, logic br,
                                logic ma, logic h, logic [4:0] en, logic [3:0] fl,
                                int stt, int cnt);
        vec_t v;
        v.st = s; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd);
        v.mr = mr; v.br = br; v.ma = ma; v.halt = h;
        v.en = en; v.fl = fl; v.state = 2'(stt); v.cnt = CW'(cnt);
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        start = v.st; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        ex_mem_read = v.mr; ex_branch_taken = v.br; mem_access = v.ma; wb_halt = v.halt;
    endtask

    task automatic check_outs(string tag, logic [4:0] en, logic [3:0] fl, int stt, int cnt);
        chk({tag, ".en"}, int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), int'(en));
        chk({tag, ".flush"}, int'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), int'(fl));
        chk({tag, ".state"}, int'(state), stt);
        chk({tag, ".cnt"}, int'(stall_count), cnt);
    endtask

    initial begin
        vec_t idle_v;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 4'b0, 0, 0);

        //          st rs1 rs2 rd mr br ma h   en        fl      st cnt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b1111, 0, 0)); // idle, no start
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b1111, 0, 0)); // start cycle still idle
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 0)); // run
        tbl.push_back(mk(0, 1, 3, 3, 1, 0, 0, 0, 5'b00111, 4'b0100, 1, 0)); // load-use rs2
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b0000, 1, 1)); // rd=0: no stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 4'b0001, 1, 1)); // freeze 1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 4'b0001, 2, 2)); // freeze 2 (MEM_WAIT)
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 4'b0000, 1, 3)); // advancing cycle
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 4'b0001, 1, 3)); // re-armed freeze
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0001, 2, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 5));
        tbl.push_back(mk(0, 5, 0, 5, 1, 1, 0, 0, 5'b11111, 4'b1100, 1, 5)); // branch beats load-use
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 4'b0001, 1, 5)); // freeze beats branch
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 5'b00000, 4'b0001, 2, 6)); // MEM_WAIT ignores br/halt
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 4'b1100, 1, 7)); // branch re-evaluated
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 4'b0000, 1, 7)); // halt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 3, 8)); // halted holds
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 3, 8)); // restart
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 0)); // count cleared
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 0)); // start ignored in RUN
        tbl.push_back(mk(0, 7, 0, 7, 1, 0, 0, 0, 5'b00111, 4'b0100, 1, 0)); // load-use rs1
        tbl.push_back(mk(0, 7, 0, 7, 0, 0, 0, 0, 5'b11111, 4'b0000, 1, 1)); // not a load

        reset = 1'b0;
        drive(idle_v);
        #3;
        check_outs("reset", 5'b00000, 4'b1111, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].en, tbl[i].fl, tbl[i].state, tbl[i].cnt);
        end

        // Saturation: 20 back-to-back load-use cycles starting from count 1.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(mk(0, 9, 0, 9, 1, 0, 0, 0, 5'b0, 4'b0, 0, 0));
            @(negedge clk);
            if (i == 14) chk("sat.reach", int'(stall_count), 15);
        end
        chk("sat.pc_en", int'(pc_en), 0);
        chk("sat.hold", int'(stall_count), 15);
        @(posedge clk); #1;
        drive(idle_v);
        @(negedge clk);
        chk("sat.nowrap", int'(stall_count), 15);

        // Reset asserted mid-freeze aborts straight to IDLE.
        @(posedge clk); #1;
        mem_access = 1'b1;
        @(posedge clk); #1;
        chk("rst.in_wait", int'(state), 2);
        reset = 1'b0;
        #1;
        check_outs("rst.abort", 5'b00000, 4'b1111, 0, 0);
        mem_access = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outs("rst.idle", 5'b00000, 4'b1111, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_outs("rst.run", 5'b11111, 4'b0000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
